irq_request_gen: RTL and testbench
==================================

// Module: irq_request_gen
// PURPOSE
//  Board-side initiator for the CPU's three external interrupt lines ir1..ir3.
//  Turns raw push-button inputs into clean, held interrupt requests.
//  Each request stays asserted until CP0 acknowledges it; lines are then tracked
//  through service until the matching ERET. One request per line may queue behind service.
//  Sits between the board controller's button inputs and the CP0 ir1/ir2/ir3 inputs.
// PARAMETERS
//  DB_CYCLES  1000000  stable-sample count for debounce (10 ms @ 100 MHz); bench overrides to 4
//  CNT_W      8        width of per-line dropped-request counters
// PORTS
//  clk        in   1        system clock
//  CLR        in   1        asynchronous, active-high reset
//  btn        in   3        raw buttons; btn[0]->ir1, btn[1]->ir2, btn[2]->ir3
//  mask       in   3        per-line enable (from sw); 0 = edges ignored, ir forced 0
//  ack        in   3        one-hot, 1-cycle pulse from CP0: handler entered for that line
//  eret       in   1        1-cycle pulse: ERET executed (ends highest in-service line)
//  ir         out  3        interrupt requests to CP0 (level)
//  ir_led     out  3        same as ir, for LEDs
//  in_service out  3        line acknowledged and not yet returned
//  drop_cnt   out  3*CNT_W  per-line saturating count of discarded edges, line0 in LSBs
// BEHAVIOUR
//  Reset (CLR=1, async): all outputs 0.
//   - Synchronizers, debounce counters and accepted levels cleared; all lines IDLE.
//  Input path per line:
//   - 2-flop synchronizer, then debounce.
//   - Counter increments while synced != accepted level; clears whenever they match.
//   - On reaching DB_CYCLES, accepted level toggles and the counter clears.
//   - Rising edge of accepted level AND mask[i] = request event (1 cycle).
//  Latency: btn[i] held high -> ir[i]=1 exactly DB_CYCLES+3 clk edges after first sampled high.
//   - Glitch shorter than DB_CYCLES synced cycles -> no event.
//  Per-line FSM (state updates on clk posedge):
//   - IDLE:   event -> PEND.
//   - PEND:   ack -> SERV. event -> stay, drop_cnt++. ack and event together -> SPND.
//   - SERV:   eret targets line -> IDLE. event -> SPND. eret and event together -> PEND.
//   - SPND:   eret targets line -> PEND. event -> drop_cnt++. ack ignored.
//  Outputs:
//   - ir[i] = (PEND|SPND) & mask[i], registered; no combinational path from inputs.
//   - in_service[i] = SERV|SPND.
//   - Deasserting mask on a PEND line hides ir but keeps PEND; ir reappears on re-enable.
//  eret target: highest index i with in_service[i]=1.
//   - eret with no line in service: ignored.
//  ack to a line not in PEND: ignored, no state change.
//  drop_cnt saturates at 2^CNT_W-1; cleared only by CLR.
//  Button release (falling accepted edge) never affects FSM state.
//  CLR mid-debounce or mid-service: everything returns to reset state.
//   - No request survives reset.
// TESTING (DB_CYCLES=4, mask=3'b111 unless stated)
//  1 btn[0] 0->1 held: ir=3'b001 exactly 7 clk after first sample; ack=3'b001 -> next cycle ir=0, in_service=001.
//  2 btn[1] pulse 3 cycles: ir stays 0 forever, drop_cnt=0.
//  3 line0 in SERV, press btn[0] again: ir[0]=1 with in_service[0]=1.
//    Then eret -> in_service[0]=0, ir[0]=1 (PEND).
//  4 lines 0 and 2 in SERV, one eret: in_service=3'b001. Second eret: in_service=0.
//  5 line1 PEND, press btn[1] 300 times: drop_cnt[15:8]=255 (saturated), ir[1]=1.
//  6 line2 PEND, mask[2]=0: ir[2]=0. mask[2]=1: ir[2]=1 next cycle.
//    Assert CLR mid-debounce of btn[0]: all outputs 0 during and after CLR.

Source files
------------

// File: rtl/irq_request_gen.sv
// irq_request_gen: debounced push-button interrupt requests for ir1..ir3, held until CP0 ack
// and tracked through service until ERET, with one queued request per line.
module irq_request_gen #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               CLR,
   input  logic [2:0]         btn,
   input  logic [2:0]         mask,
   input  logic [2:0]         ack,
   input  logic               eret,
   output logic [2:0]         ir,
   output logic [2:0]         ir_led,
   output logic [2:0]         in_service,
   output logic [3*CNT_W-1:0] drop_cnt
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_M1 = CW'(DB_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, PEND, SERV, SPND} st_e;
   logic [2:0] s1_q, s2_q, acc_q, acc_d, acc_p_q, ev, tgt, er, inc, ir_q, ir_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic [CNT_W-1:0] dc_q [3];
   logic [CNT_W-1:0] dc_d [3];
   st_e st_q [3];
   st_e st_d [3];
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         acc_d[i] = acc_q[i] ^ ((s2_q[i] ^ acc_q[i]) && cnt_q[i] == DB_M1);
         cnt_d[i] = (!(s2_q[i] ^ acc_q[i]) || cnt_q[i] == DB_M1) ? '0 : cnt_q[i] + 1'b1;
      end
   end
   assign ev = acc_q & ~acc_p_q & mask;
   always_comb begin
      for (int i = 0; i < 3; i++)
         in_service[i] = st_q[i] == SERV || st_q[i] == SPND;
   end
   // ERET always closes the highest-numbered line currently in service
   assign tgt = in_service[2] ? 3'b100 : in_service[1] ? 3'b010 : in_service[0] ? 3'b001 : 3'b000;
   assign er  = tgt & {3{eret}};
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         st_d[i] = st_q[i];
         inc[i]  = 1'b0;
         case (st_q[i])
            IDLE: st_d[i] = ev[i] ? PEND : IDLE;
            PEND: begin
               st_d[i] = ack[i] ? (ev[i] ? SPND : SERV) : PEND;
               inc[i]  = ev[i] && !ack[i];
            end
            SERV: st_d[i] = er[i] ? (ev[i] ? PEND : IDLE) : (ev[i] ? SPND : SERV);
            SPND: begin
               st_d[i] = er[i] ? PEND : SPND;
               inc[i]  = ev[i];
            end
            default: st_d[i] = IDLE;
         endcase
         ir_d[i] = (st_d[i] == PEND || st_d[i] == SPND) && mask[i];
         dc_d[i] = dc_q[i] + CNT_W'(inc[i] && !(&dc_q[i]));
      end
   end
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         s1_q    <= '0;
         s2_q    <= '0;
         acc_q   <= '0;
         acc_p_q <= '0;
         ir_q    <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
            dc_q[i]  <= '0;
            st_q[i]  <= IDLE;
         end
      end else begin
         s1_q    <= btn;
         s2_q    <= s1_q;
         acc_q   <= acc_d;
         acc_p_q <= acc_q;
         ir_q    <= ir_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
            dc_q[i]  <= dc_d[i];
            st_q[i]  <= st_d[i];
         end
      end
   end
   assign ir     = ir_q;
   assign ir_led = ir_q;
   for (genvar g = 0; g < 3; g++) begin : g_dc
      assign drop_cnt[g*CNT_W +: CNT_W] = dc_q[g];
   end
endmodule

// File: tb/tb_irq_request_gen.sv
// tb_irq_request_gen: directed checks of debounce latency, FSM service/queue flow,
// ERET priority, drop saturation, masking and async reset.
module tb_irq_request_gen;
   logic        clk = 1'b0;
   logic        CLR = 1'b1;
   logic [2:0]  btn = '0, mask = 3'b111, ack = '0;
   logic        eret = 1'b0;
   logic [2:0]  ir, ir_led, in_service;
   logic [23:0] drop_cnt;
   int checks = 0, errors = 0;
   irq_request_gen #(.DB_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .CLR(CLR), .btn(btn), .mask(mask), .ack(ack), .eret(eret),
      .ir(ir), .ir_led(ir_led), .in_service(in_service), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic press(input int i);
      btn[i] = 1'b1;
      tick(7);
      btn[i] = 1'b0;
      tick(8);
   endtask
   task automatic pulse_ack(input logic [2:0] a);
      ack = a;
      tick();
      ack = '0;
   endtask
   task automatic pulse_eret();
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask
   initial begin
      tick(2);
      check("rst_ir", ir, 0);
      check("rst_svc", in_service, 0);
      check("rst_drop", drop_cnt, 0);
      CLR = 1'b0;
      tick();
      pulse_eret();
      check("eret_none", in_service, 0);
      // 1: latency and ack
      btn = 3'b001;
      tick(6);
      check("lat_before", ir, 0);
      tick();
      check("lat_ir", ir, 3'b001);
      check("lat_led", ir_led, 3'b001);
      pulse_ack(3'b001);
      check("ack_ir", ir, 0);
      check("ack_svc", in_service, 3'b001);
      btn = '0;
      tick(10);
      check("release_svc", in_service, 3'b001);
      check("release_ir", ir, 0);
      // 2: short glitch
      btn = 3'b010;
      tick(3);
      btn = '0;
      tick(12);
      check("glitch_ir", ir, 0);
      check("glitch_drop", drop_cnt, 0);
      // 3: press during service, then eret
      press(0);
      check("spnd_ir", ir, 3'b001);
      check("spnd_svc", in_service, 3'b001);
      pulse_eret();
      check("spnd_eret_svc", in_service, 0);
      check("spnd_eret_ir", ir, 3'b001);
      pulse_ack(3'b001);
      check("reack_svc", in_service, 3'b001);
      check("reack_ir", ir, 0);
      // 4: eret priority
      press(2);
      check("l2_pend_ir", ir, 3'b100);
      pulse_ack(3'b100);
      check("two_svc", in_service, 3'b101);
      pulse_eret();
      check("eret1_svc", in_service, 3'b001);
      pulse_eret();
      check("eret2_svc", in_service, 0);
      check("eret2_ir", ir, 0);
      pulse_ack(3'b001);
      check("ack_idle", in_service, 0);
      // 5: drop saturation
      press(1);
      check("l1_pend_ir", ir, 3'b010);
      press(1);
      check("drop_one", drop_cnt, 24'h000100);
      for (int k = 0; k < 299; k++) press(1);
      check("drop_sat", drop_cnt, 24'h00ff00);
      check("sat_ir", ir, 3'b010);
      // 6: masking and reset
      press(2);
      check("mask_pre", ir, 3'b110);
      mask = 3'b011;
      tick();
      check("mask_off", ir, 3'b010);
      mask = 3'b111;
      #1;
      check("mask_nocomb", ir, 3'b010);
      tick();
      check("mask_on", ir, 3'b110);
      btn = 3'b001;
      tick(3);
      CLR = 1'b1;
      #1;
      check("clr_ir", ir, 0);
      check("clr_drop", drop_cnt, 0);
      check("clr_svc", in_service, 0);
      tick(2);
      btn = '0;
      CLR = 1'b0;
      tick(10);
      check("post_ir", ir, 0);
      check("post_led", ir_led, 0);
      check("post_drop", drop_cnt, 0);
      check("post_svc", in_service, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
